// File: rtl/axi_rresp_gen_if.sv
// Bundle of the ID-FIFO, AHB read-beat and AXI R-channel signals around axi_rresp_gen.
// The slave modport is the block itself; the master modport is its environment.
interface axi_rresp_gen_if #(
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_DATA_WIDTH = 32
);
    logic [AXI_ID_WIDTH:0]     id_fifo_data;
    logic                      id_fifo_empty;
    logic                      id_fifo_rd_en;
    logic                      beat_valid;
    logic [AXI_DATA_WIDTH-1:0] beat_data;
    logic                      beat_err;
    logic                      beat_ready;
    logic                      rvalid;
    logic                      rready;
    logic [AXI_ID_WIDTH-1:0]   rid;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      burst_done;
    logic [7:0]                beat_cnt;

    modport slave (
        input  id_fifo_data, id_fifo_empty, beat_valid, beat_data, beat_err, rready,
        output id_fifo_rd_en, beat_ready, rvalid, rid, rdata, rresp, rlast,
               burst_done, beat_cnt
    );

    modport master (
        output id_fifo_data, id_fifo_empty, beat_valid, beat_data, beat_err, rready,
        input  id_fifo_rd_en, beat_ready, rvalid, rid, rdata, rresp, rlast,
               burst_done, beat_cnt
    );
endinterface

// File: rtl/axi_rresp_gen.sv
// Turns AHB read beats plus queued {last, id} entries into AXI R-channel beats
// through a 2-entry skid queue, with per-burst beat counting and a done pulse.
module axi_rresp_gen #(
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic          rclk,
    input  logic          resetn,
    axi_rresp_gen_if.slave bus
);
    logic [1:0]                count_q;
    logic [1:0]                count_d;
    logic                      wr_ptr_q;
    logic                      rd_ptr_q;
    logic [AXI_ID_WIDTH-1:0]   q_id   [2];
    logic [AXI_DATA_WIDTH-1:0] q_data [2];
    logic [1:0]                q_resp [2];
    logic                      q_last [2];
    logic                      rvalid_q;
    logic                      burst_done_q;
    logic [7:0]                beat_cnt_q;
    logic                      drain;
    logic                      accept;

    assign drain  = rvalid_q && bus.rready;

    // Gating with resetn keeps the ID FIFO from being popped while held in reset.
    assign bus.beat_ready = ((count_q < 2'd2) || drain) && !bus.id_fifo_empty && resetn;
    assign accept         = bus.beat_valid && bus.beat_ready;
    assign bus.id_fifo_rd_en = accept;

    always_comb begin
        count_d = count_q;
        unique case ({accept, drain})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge rclk or negedge resetn) begin
        if (!resetn) begin
            count_q      <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            burst_done_q <= 1'b0;
            beat_cnt_q   <= 8'd0;
            for (int i = 0; i < 2; i++) begin
                q_id[i]   <= '0;
                q_data[i] <= '0;
                q_resp[i] <= 2'b00;
                q_last[i] <= 1'b0;
            end
        end else begin
            // FIFO data is only valid during the pop cycle, so it is captured here.
            if (accept) begin
                q_id[wr_ptr_q]   <= bus.id_fifo_data[AXI_ID_WIDTH-1:0];
                q_last[wr_ptr_q] <= bus.id_fifo_data[AXI_ID_WIDTH];
                q_data[wr_ptr_q] <= bus.beat_data;
                q_resp[wr_ptr_q] <= bus.beat_err ? 2'b10 : 2'b00;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (drain) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q      <= count_d;
            rvalid_q     <= (count_d != 2'd0);
            burst_done_q <= drain && q_last[rd_ptr_q];
            if (drain) begin
                if (q_last[rd_ptr_q]) begin
                    beat_cnt_q <= 8'd0;
                end else if (beat_cnt_q != 8'd255) begin
                    beat_cnt_q <= beat_cnt_q + 8'd1;
                end
            end
        end
    end

    assign bus.rvalid     = rvalid_q;
    assign bus.rid        = q_id[rd_ptr_q];
    assign bus.rdata      = q_data[rd_ptr_q];
    assign bus.rresp      = q_resp[rd_ptr_q];
    assign bus.rlast      = q_last[rd_ptr_q];
    assign bus.burst_done = burst_done_q;
    assign bus.beat_cnt   = beat_cnt_q;
endmodule

// File: tb/tb_axi_rresp_gen.sv
// Directed bench for axi_rresp_gen: per-cycle vector table plus hand-written
// backpressure, throughput and reset sequences.
module tb_axi_rresp_gen;
    logic rclk;
    logic resetn;

    axi_rresp_gen_if #(.AXI_ID_WIDTH(8), .AXI_DATA_WIDTH(32)) bus ();

    axi_rresp_gen #(.AXI_ID_WIDTH(8), .AXI_DATA_WIDTH(32)) dut (
        .rclk   (rclk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        emp;
        logic [8:0]  fdat;
        logic        bv;
        logic [31:0] bd;
        logic        be;
        logic        rr;
        logic        br;
        logic        pop;
        logic        rv;
        logic [7:0]  rid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        bdone;
        logic [7:0]  bcnt;
    } vec_t;

    vec_t vecs [9];

    // Drives one beat of a generated burst: entry p of n, ID idb+p, data db+p.
    task automatic drive_src(input int p, input int n, input logic [7:0] idb, input logic [31:0] db);
        if (p < n) begin
            bus.id_fifo_empty = 1'b0;
            bus.id_fifo_data  = {(p == n - 1), idb + 8'(p)};
            bus.beat_valid    = 1'b1;
            bus.beat_data     = db + 32'(p);
            bus.beat_err      = 1'b0;
        end else begin
            bus.id_fifo_empty = 1'b1;
            bus.id_fifo_data  = 9'h000;
            bus.beat_valid    = 1'b0;
            bus.beat_data     = 32'h0;
            bus.beat_err      = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pops;
        int k;
        int n_hs;
        int cyc;
        int first_cyc;
        int last_cyc;

        // emp fdat bv bd be rr | br pop rv rid rdata rresp rlast bdone bcnt
        vecs[0] = '{1'b0, 9'h15A, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 1'b0, 8'd0};
        vecs[1] = '{1'b1, 9'h000, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 32'hDEADBEEF, 2'b00, 1'b1, 1'b0, 8'd0};
        vecs[2] = '{1'b1, 9'h000, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 1'b1, 8'd0};
        vecs[3] = '{1'b0, 9'h033, 1'b1, 32'h11111111, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 1'b0, 8'd0};
        vecs[4] = '{1'b0, 9'h033, 1'b1, 32'h22222222, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 32'h11111111, 2'b00, 1'b0, 1'b0, 8'd0};
        vecs[5] = '{1'b0, 9'h133, 1'b1, 32'h33333333, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 32'h22222222, 2'b10, 1'b0, 1'b0, 8'd1};
        vecs[6] = '{1'b1, 9'h000, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 32'h33333333, 2'b00, 1'b1, 1'b0, 8'd2};
        vecs[7] = '{1'b1, 9'h000, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 1'b1, 8'd0};
        vecs[8] = '{1'b1, 9'h000, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 1'b0, 8'd0};

        resetn = 1'b0;
        drive_src(0, 0, 8'h00, 32'h0);
        bus.rready = 1'b0;
        repeat (3) @(posedge rclk);
        #1;
        check("rst_rvalid",     32'(bus.rvalid),     32'd0);
        check("rst_burst_done", 32'(bus.burst_done), 32'd0);
        check("rst_beat_cnt",   32'(bus.beat_cnt),   32'd0);
        check("rst_rid",        32'(bus.rid),        32'd0);
        check("rst_rdata",      bus.rdata,           32'd0);
        check("rst_rresp",      32'(bus.rresp),      32'd0);
        check("rst_rlast",      32'(bus.rlast),      32'd0);
        resetn = 1'b1;

        // Per-cycle table: single beat, then a 3-beat burst with an error on beat 2,
        // then beat_valid against an empty ID FIFO.
        for (int i = 0; i < 9; i++) begin
            bus.id_fifo_empty = vecs[i].emp;
            bus.id_fifo_data  = vecs[i].fdat;
            bus.beat_valid    = vecs[i].bv;
            bus.beat_data     = vecs[i].bd;
            bus.beat_err      = vecs[i].be;
            bus.rready        = vecs[i].rr;
            @(negedge rclk);
            check($sformatf("v%0d_beat_ready", i), 32'(bus.beat_ready),    32'(vecs[i].br));
            check($sformatf("v%0d_rd_en", i),      32'(bus.id_fifo_rd_en), 32'(vecs[i].pop));
            check($sformatf("v%0d_rvalid", i),     32'(bus.rvalid),        32'(vecs[i].rv));
            check($sformatf("v%0d_burst_done", i), 32'(bus.burst_done),    32'(vecs[i].bdone));
            check($sformatf("v%0d_beat_cnt", i),   32'(bus.beat_cnt),      32'(vecs[i].bcnt));
            if (vecs[i].rv) begin
                check($sformatf("v%0d_rid", i),   32'(bus.rid),   32'(vecs[i].rid));
                check($sformatf("v%0d_rdata", i), bus.rdata,      vecs[i].rdata);
                check($sformatf("v%0d_rresp", i), 32'(bus.rresp), 32'(vecs[i].rresp));
                check($sformatf("v%0d_rlast", i), 32'(bus.rlast), 32'(vecs[i].rlast));
            end
            @(posedge rclk);
            #1;
        end

        // Backpressure: 4-beat burst with rready low fills the queue after 2 pops.
        pops = 0;
        bus.rready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive_src(pops, 4, 8'hA0, 32'hB0000000);
            @(negedge rclk);
            if (bus.id_fifo_rd_en) pops++;
            @(posedge rclk);
            #1;
        end
        drive_src(pops, 4, 8'hA0, 32'hB0000000);
        @(negedge rclk);
        check("bp_pops",       32'(pops),              32'd2);
        check("bp_beat_ready", 32'(bus.beat_ready),    32'd0);
        check("bp_rd_en",      32'(bus.id_fifo_rd_en), 32'd0);
        check("bp_rvalid",     32'(bus.rvalid),        32'd1);
        @(posedge rclk);
        #1;
        bus.rready = 1'b1;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            drive_src(pops, 4, 8'hA0, 32'hB0000000);
            @(negedge rclk);
            if (bus.id_fifo_rd_en) pops++;
            if (bus.rvalid && bus.rready) begin
                check($sformatf("bp_rid%0d", k),   32'(bus.rid),      32'(8'hA0 + 8'(k)));
                check($sformatf("bp_rdata%0d", k), bus.rdata,         32'hB0000000 + 32'(k));
                check($sformatf("bp_rlast%0d", k), 32'(bus.rlast),    32'(k == 3));
                check($sformatf("bp_bcnt%0d", k),  32'(bus.beat_cnt), 32'(k));
                k++;
            end
            @(posedge rclk);
            #1;
        end
        check("bp_drained", 32'(k), 32'd4);
        drive_src(4, 4, 8'h00, 32'h0);
        @(negedge rclk);
        check("bp_burst_done", 32'(bus.burst_done), 32'd1);
        check("bp_bcnt_clear", 32'(bus.beat_cnt),   32'd0);
        @(posedge rclk);
        #1;

        // Full throughput: 8 back-to-back beats with rready held high.
        pops = 0;
        n_hs = 0;
        first_cyc = -1;
        last_cyc = -1;
        cyc = 0;
        bus.rready = 1'b1;
        for (int c = 0; c < 30 && n_hs < 8; c++) begin
            drive_src(pops, 8, 8'hC0, 32'hC0DE0000);
            @(negedge rclk);
            if (pops < 8) check($sformatf("tp_ready%0d", pops), 32'(bus.beat_ready), 32'd1);
            if (bus.id_fifo_rd_en) pops++;
            if (bus.rvalid && bus.rready) begin
                check($sformatf("tp_rid%0d", n_hs), 32'(bus.rid), 32'(8'hC0 + 8'(n_hs)));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                n_hs++;
            end
            cyc++;
            @(posedge rclk);
            #1;
        end
        check("tp_handshakes", 32'(n_hs), 32'd8);
        check("tp_span",       32'(last_cyc - first_cyc), 32'd7);

        // Reset with a full queue: rvalid drops at once, no pops, no stale beat after release.
        pops = 0;
        bus.rready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive_src(pops, 4, 8'hE0, 32'hE0000000);
            @(negedge rclk);
            if (bus.id_fifo_rd_en) pops++;
            @(posedge rclk);
            #1;
        end
        drive_src(pops, 4, 8'hE0, 32'hE0000000);
        @(negedge rclk);
        check("rf_full_ready", 32'(bus.beat_ready), 32'd0);
        check("rf_rvalid",     32'(bus.rvalid),     32'd1);
        #1;
        resetn = 1'b0;
        #1;
        check("rf_rvalid_drop", 32'(bus.rvalid),        32'd0);
        check("rf_no_pop",      32'(bus.id_fifo_rd_en), 32'd0);
        @(posedge rclk);
        #1;
        check("rf_no_pop_edge", 32'(bus.id_fifo_rd_en), 32'd0);
        @(negedge rclk);
        resetn = 1'b1;
        drive_src(4, 4, 8'h00, 32'h0);
        bus.rready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge rclk);
            check($sformatf("rf_stale%0d", c), 32'(bus.rvalid), 32'd0);
        end
        @(posedge rclk);
        #1;
        bus.id_fifo_empty = 1'b0;
        bus.id_fifo_data  = 9'h177;
        bus.beat_valid    = 1'b1;
        bus.beat_data     = 32'h77777777;
        bus.beat_err      = 1'b0;
        @(negedge rclk);
        check("rf_post_pop", 32'(bus.id_fifo_rd_en), 32'd1);
        @(posedge rclk);
        #1;
        drive_src(4, 4, 8'h00, 32'h0);
        @(negedge rclk);
        check("rf_post_rvalid", 32'(bus.rvalid), 32'd1);
        check("rf_post_rid",    32'(bus.rid),    32'h77);
        check("rf_post_rdata",  bus.rdata,       32'h77777777);
        @(posedge rclk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
